// File: rtl/uart_echo_ctrl.sv
// uart_echo_ctrl: byte-echo responder between a UART_Rx and a UART_Tx.
// Received bytes (rising edge of rx_val) are queued in a small FIFO and
// replayed in order through the tx_val/busy handshake. tx_sel tells the
// shared baud generator that the echo transmitter currently owns it.
// Optional build macro ECHO_UPPER_EN: fold 'a'..'z' to upper case on push.
module uart_echo_ctrl #(
    parameter int DEPTH        = 8,
    parameter int ADDR_W       = 3,
    parameter int BUSY_TIMEOUT = 64,
    parameter int GAP_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_val,
    input  logic [7:0]        rx_data,
    input  logic              busy,
    input  logic              clr_ovf,
    output logic              tx_val,
    output logic [7:0]        tx_data,
    output logic              tx_sel,
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    output logic              timeout
);

    localparam int TCNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ADDR_W:0]   FULL      = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REQ,
        WAIT_LO,
        GAP
    } state_t;

    state_t            state, state_next;
    logic [TCNT_W-1:0] tcnt, tcnt_next;
    logic [GCNT_W-1:0] gcnt, gcnt_next;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              rx_val_d;
    logic              push, pop, accept, load;
    logic [7:0]        push_byte;

    // Byte transform applied on the way into the FIFO.
    function automatic logic [7:0] fold_case(input logic [7:0] b);
`ifdef ECHO_UPPER_EN
        if (b >= 8'h61 && b <= 8'h7A) begin
            return b - 8'h20;
        end
`endif
        return b;
    endfunction

    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push      = rx_val & ~rx_val_d;
    assign accept    = push & ((count != FULL) | pop);
    assign push_byte = fold_case(rx_data);

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_byte;
        end
    end

    // FIFO pointers, occupancy, overflow flag, edge detect and tx_data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_val_d <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            rx_val_d <= rx_val;
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A fresh overflow takes priority over a clear in the same cycle.
            if (push & ~accept) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
            if (load) begin
                tx_data <= mem[rd_ptr];
            end
        end
    end

    // Transmit FSM state and its cycle counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tcnt  <= '0;
            gcnt  <= '0;
        end else begin
            state <= state_next;
            tcnt  <= tcnt_next;
            gcnt  <= gcnt_next;
        end
    end

    // Next-state and handshake outputs; busy seen in REQ is the acceptance.
    always_comb begin
        state_next = state;
        tcnt_next  = tcnt;
        gcnt_next  = gcnt;
        tx_val     = 1'b0;
        tx_sel     = 1'b0;
        timeout    = 1'b0;
        pop        = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                tx_sel     = 1'b1;
                load       = 1'b1;
                tcnt_next  = '0;
                state_next = REQ;
            end
            REQ: begin
                tx_val = 1'b1;
                tx_sel = 1'b1;
                if (busy) begin
                    pop        = 1'b1;
                    tcnt_next  = '0;
                    state_next = WAIT_LO;
                end else if (tcnt == TCNT_LAST) begin
                    // Give up on this attempt; the head stays queued for a retry.
                    timeout    = 1'b1;
                    tcnt_next  = '0;
                    state_next = IDLE;
                end else begin
                    tcnt_next = tcnt + 1'b1;
                end
            end
            WAIT_LO: begin
                tx_sel = 1'b1;
                if (!busy) begin
                    gcnt_next = '0;
                    if (GAP_CYCLES == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (gcnt == GCNT_LAST) begin
                    gcnt_next  = '0;
                    state_next = IDLE;
                end else begin
                    gcnt_next = gcnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Bench for uart_echo_ctrl: a queue-based reference model checked against the
// DUT every cycle, plus directed scenarios with literal expected values.
module tb_uart_echo_ctrl;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int TO     = 64;
    localparam int NGAP   = 2;

    logic              clk = 1'b0;
    logic              rst, rx_val, busy, clr_ovf;
    logic [7:0]        rx_data, tx_data;
    logic              tx_val, tx_sel, ovf, timeout;
    logic [ADDR_W:0]   count;

    always #5 clk = ~clk;

    uart_echo_ctrl #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BUSY_TIMEOUT(TO), .GAP_CYCLES(NGAP)
    ) dut (
        .clk(clk), .rst(rst), .rx_val(rx_val), .rx_data(rx_data),
        .busy(busy), .clr_ovf(clr_ovf), .tx_val(tx_val), .tx_data(tx_data),
        .tx_sel(tx_sel), .count(count), .ovf(ovf), .timeout(timeout)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_LOAD = 1, M_REQ = 2, M_WAIT = 3, M_GAP = 4;

    logic [7:0] mq[$];
    logic [7:0] echo_q[$];
    int         to_cyc[$];
    int         ph = M_IDLE;
    int         age = 0;
    int         gap_left = 0;
    bit         m_ovf = 0;
    logic [7:0] m_txd = 8'h00;
    bit         m_rxd = 0;
    bit         armed = 0;
    int         cyc = 0;

    function automatic logic [7:0] m_store(input logic [7:0] b);
`ifdef ECHO_UPPER_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    always @(posedge clk) begin
        bit m_push, m_pop, rej;
        cyc++;
        if (rst) begin
            mq.delete();
            ph = M_IDLE; age = 0; gap_left = 0;
            m_ovf = 0; m_txd = 8'h00; m_rxd = 0; armed = 1;
        end else begin
            m_push = rx_val && !m_rxd;
            m_pop  = 0;
            case (ph)
                M_IDLE: if (mq.size() != 0) ph = M_LOAD;
                M_LOAD: begin m_txd = mq[0]; ph = M_REQ; age = 0; end
                M_REQ: begin
                    if (busy) begin m_pop = 1; ph = M_WAIT; end
                    else if (age == TO - 1) ph = M_IDLE;
                    else age++;
                end
                M_WAIT: if (!busy) begin
                    if (NGAP == 0) ph = M_IDLE;
                    else begin ph = M_GAP; gap_left = NGAP; end
                end
                default: begin gap_left--; if (gap_left == 0) ph = M_IDLE; end
            endcase
            if (m_pop) void'(mq.pop_front());
            rej = m_push && (mq.size() >= DEPTH);
            if (m_push && !rej) mq.push_back(m_store(rx_data));
            if (rej) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            m_rxd = rx_val;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (armed) begin
            chk("tx_val",  tx_val,  ph == M_REQ);
            chk("tx_sel",  tx_sel,  ph == M_LOAD || ph == M_REQ || ph == M_WAIT);
            chk("tx_data", tx_data, m_txd);
            chk("count",   count,   mq.size());
            chk("ovf",     ovf,     m_ovf);
            chk("timeout", timeout, ph == M_REQ && !busy && age == TO - 1);
            if (tx_val === 1'b1 && busy === 1'b1) echo_q.push_back(tx_data);
            if (timeout === 1'b1) to_cyc.push_back(cyc);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b; rx_val = 1'b1; tick();
        rx_val = 1'b0; tick();
    endtask

    task automatic wait_tx();
        int n = 0;
        while (tx_val !== 1'b1 && n < 200) begin tick(); n++; end
        chk("wait_tx_val", tx_val, 1);
    endtask

    task automatic serve();
        wait_tx();
        busy = 1'b1; tick();
        tick(2);
        busy = 1'b0; tick();
    endtask

    task automatic chk_echo(input string name, input int idx, input logic [7:0] exp);
        if (idx < echo_q.size()) chk(name, echo_q[idx], exp);
        else chk(name, 32'hFFFF_FFFF, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_val = 1'b0; busy = 1'b0; clr_ovf = 1'b0;
        tick();
        rst = 1'b0;
        echo_q.delete(); to_cyc.delete();
    endtask

    initial begin
        rst = 1'b1; rx_val = 1'b0; rx_data = 8'h00; busy = 1'b0; clr_ovf = 1'b0;
        tick(2);
        chk("rst_tx_val", tx_val, 0);
        chk("rst_tx_sel", tx_sel, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b0;

        // Single echo with latency pinning
        rx_data = 8'hAC; rx_val = 1'b1; tick();
        chk("single_count1", count, 1);
        chk("single_no_tx_yet", tx_val, 0);
        rx_val = 1'b0; tick();
        chk("single_load_sel", tx_sel, 1);
        chk("single_load_noval", tx_val, 0);
        tick();
        chk("single_tx_val", tx_val, 1);
        chk("single_tx_data", tx_data, 8'hAC);
        tick(); busy = 1'b1; tick();
        chk("single_val_drop", tx_val, 0);
        chk("single_wait_sel", tx_sel, 1);
        chk("single_count0", count, 0);
        chk("single_echo_n", echo_q.size(), 1);
        chk_echo("single_echo0", 0, 8'hAC);
        tick(2); busy = 1'b0; tick();
        chk("single_gap_sel", tx_sel, 0);
        tick(2);
        chk("single_idle_val", tx_val, 0);

        // Burst order while the transmitter is held busy
        echo_q.delete();
        send(8'h99);
        wait_tx();
        busy = 1'b1; tick();
        send(8'h11); send(8'h22); send(8'h33);
        chk("burst_count3", count, 3);
        busy = 1'b0; tick();
        repeat (3) serve();
        chk("burst_echo_n", echo_q.size(), 4);
        chk_echo("burst_e0", 0, 8'h99);
        chk_echo("burst_e1", 1, 8'h11);
        chk_echo("burst_e2", 2, 8'h22);
        chk_echo("burst_e3", 3, 8'h33);

        // Overflow with busy never rising: retries every 66 cycles
        do_reset();
        for (int i = 0; i < 9; i++) send(8'(i));
        chk("ovf_count8", count, 8);
        chk("ovf_set", ovf, 1);
        tick(200);
        chk("ovf_timeouts_seen", to_cyc.size() >= 3, 1);
        for (int i = 1; i < to_cyc.size(); i++)
            chk("ovf_timeout_period", to_cyc[i] - to_cyc[i-1], 66);
        chk("ovf_sticky", ovf, 1);
        chk("ovf_count_hold", count, 8);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        chk("ovf_cleared", ovf, 0);
        repeat (8) serve();
        chk("ovf_echo_n", echo_q.size(), 8);
        for (int i = 0; i < 8; i++) chk_echo("ovf_echo", i, 8'(i));
        chk("ovf_drain", count, 0);

        // Level rx_val pushes once
        do_reset();
        rx_data = 8'h5A; rx_val = 1'b1; tick(20);
        chk("level_count1", count, 1);
        rx_val = 1'b0; tick();
        serve();
        chk_echo("level_echo", 0, 8'h5A);
        chk("level_drain", count, 0);

        // Full FIFO, push coinciding with the accepting REQ cycle
        do_reset();
        for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i));
        chk("fullpop_count8", count, 8);
        wait_tx();
        rx_data = 8'hB8; rx_val = 1'b1; busy = 1'b1; tick();
        chk("fullpop_count_hold", count, 8);
        chk("fullpop_no_ovf", ovf, 0);
        rx_val = 1'b0; tick(2); busy = 1'b0; tick();
        repeat (8) serve();
        chk("fullpop_echo_n", echo_q.size(), 9);
        for (int i = 0; i < 8; i++) chk_echo("fullpop_echo", i, 8'hA0 + 8'(i));
        chk_echo("fullpop_echo_b8", 8, 8'hB8);

        // Case folding boundaries
        do_reset();
        send(8'h61); send(8'h7B); send(8'h7A); send(8'h60);
        repeat (4) serve();
`ifdef ECHO_UPPER_EN
        chk_echo("case_61", 0, 8'h41);
        chk_echo("case_7A", 2, 8'h5A);
`else
        chk_echo("case_61", 0, 8'h61);
        chk_echo("case_7A", 2, 8'h7A);
`endif
        chk_echo("case_7B", 1, 8'h7B);
        chk_echo("case_60", 3, 8'h60);

        // Reset in the middle of a request
        do_reset();
        send(8'hC1); send(8'hC2);
        wait_tx();
        rst = 1'b1; tick();
        chk("midrst_tx_val", tx_val, 0);
        chk("midrst_tx_sel", tx_sel, 0);
        chk("midrst_count", count, 0);
        chk("midrst_tx_data", tx_data, 0);
        rst = 1'b0; tick(3);
        chk("midrst_stay_empty", count, 0);
        chk("midrst_stay_idle", tx_val, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
